// File: rtl/sccb_reader.sv
`default_nettype none
// ============================================================================
// sccb_reader : SCCB (OV7670) register read master. It writes the ID and the
//               sub-address, then reads the ID, the data byte and a master NA.
// Rev 1.0
// ============================================================================
module sccb_reader #(
  parameter logic [7:0] WR_ID          = 8'h42,
  parameter logic [7:0] RD_ID          = 8'h43,
  parameter int         QUARTER_CYCLES = 62
) (
  input  logic       clk_25M,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] address,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_oe,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       ready,
  output logic       no_ack
);

  localparam int            QW     = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QUARTER_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, START_A, TX_ID_W, TX_ADDR, STOP_A, GAP,
    START_B, TX_ID_R, RX_DATA, NA, STOP_B, DONE
  } state_t;

  state_t        state, state_d;
  logic [QW-1:0] qcnt, qcnt_d;
  logic [5:0]    qidx, qidx_d;
  logic [7:0]    addr_reg;
  logic [7:0]    shift_reg, shift_d;
  logic [7:0]    data_d;
  logic [7:0]    tx_byte;
  logic [1:0]    drive_d;
  logic          no_ack_d, data_valid_d;
  logic          sda_meta, sda_sync;
  logic          tick, sample;

  // Index of the final quarter spent in each timed state.
  function automatic logic [5:0] last_quarter(input state_t s);
    case (s)
      TX_ID_W, TX_ADDR, TX_ID_R: last_quarter = 6'd35;
      RX_DATA:                   last_quarter = 6'd31;
      default:                   last_quarter = 6'd3;
    endcase
  endfunction

  function automatic state_t next_of(input state_t s);
    case (s)
      START_A: next_of = TX_ID_W;
      TX_ID_W: next_of = TX_ADDR;
      TX_ADDR: next_of = STOP_A;
      STOP_A:  next_of = GAP;
      GAP:     next_of = START_B;
      START_B: next_of = TX_ID_R;
      TX_ID_R: next_of = RX_DATA;
      RX_DATA: next_of = NA;
      NA:      next_of = STOP_B;
      STOP_B:  next_of = DONE;
      default: next_of = IDLE;
    endcase
  endfunction

  // Bus levels {scl, sda_oe} for a given state and quarter index.
  function automatic logic [1:0] bus_drive(input state_t s, input logic [5:0] qi,
                                           input logic [7:0] tx);
    logic [1:0] ph;
    logic [3:0] bn;
    ph = qi[1:0];
    bn = qi[5:2];
    case (s)
      START_A, START_B:          bus_drive = {ph != 2'd3, ph[1]};
      STOP_A, STOP_B:            bus_drive = {ph != 2'd0, ~ph[1]};
      TX_ID_W, TX_ADDR, TX_ID_R: bus_drive = {ph[1], (bn < 4'd8) ? ~tx[3'd7 - bn[2:0]] : 1'b0};
      RX_DATA, NA:               bus_drive = {ph[1], 1'b0};
      default:                   bus_drive = 2'b10;
    endcase
  endfunction

  assign tick   = (qcnt == Q_LAST);
  assign sample = tick && (qidx[1:0] == 2'd2);
  assign ready  = (state == IDLE);

  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      state      <= IDLE;
      qcnt       <= '0;
      qidx       <= '0;
      addr_reg   <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      no_ack     <= 1'b0;
      scl        <= 1'b1;
      sda_oe     <= 1'b0;
      sda_meta   <= 1'b1;
      sda_sync   <= 1'b1;
    end else begin
      state      <= state_d;
      qcnt       <= qcnt_d;
      qidx       <= qidx_d;
      shift_reg  <= shift_d;
      data_out   <= data_d;
      data_valid <= data_valid_d;
      no_ack     <= no_ack_d;
      scl        <= drive_d[1];
      sda_oe     <= drive_d[0];
      sda_meta   <= sda_in;
      sda_sync   <= sda_meta;
      if (state == IDLE && start)
        addr_reg <= address;
    end
  end

  always_comb begin
    state_d      = state;
    qcnt_d       = qcnt;
    qidx_d       = qidx;
    shift_d      = shift_reg;
    no_ack_d     = no_ack;
    data_d       = data_out;
    data_valid_d = 1'b0;
    tx_byte      = 8'h00;

    case (state)
      IDLE: begin
        if (start) begin
          state_d  = START_A;
          qcnt_d   = '0;
          qidx_d   = '0;
          no_ack_d = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        qcnt_d = tick ? '0 : qcnt + QW'(1);
        if (tick) begin
          if (qidx == last_quarter(state)) begin
            qidx_d  = '0;
            state_d = next_of(state);
          end else begin
            qidx_d = qidx + 6'd1;
          end
        end
        // Write-byte 9th bits only flag no_ack; they never abort the read.
        if (sample) begin
          case (state)
            TX_ID_W, TX_ADDR, TX_ID_R: if (qidx == 6'd34 && sda_sync) no_ack_d = 1'b1;
            RX_DATA:                   shift_d = {shift_reg[6:0], sda_sync};
            default:                   ;
          endcase
        end
      end
    endcase

    if (state_d == DONE) begin
      data_d       = shift_d;
      data_valid_d = 1'b1;
    end

    case (state_d)
      TX_ID_W: tx_byte = WR_ID;
      TX_ADDR: tx_byte = addr_reg;
      TX_ID_R: tx_byte = RD_ID;
      default: tx_byte = 8'h00;
    endcase

    // Outputs are registered from the next state so they stay aligned with it.
    drive_d = bus_drive(state_d, qidx_d, tx_byte);
  end

endmodule
`default_nettype wire

// File: tb/tb_sccb_reader.sv
`default_nettype none
// ============================================================================
// tb_sccb_reader : scoreboard bench for sccb_reader with an SCCB slave model.
// Rev 1.0
// ============================================================================
module tb_sccb_reader;

  localparam int Q       = 4;
  localparam int DV_OFS  = 164 * Q + 1;   // 657
  localparam int RDY_OFS = 164 * Q + 2;   // 658
  localparam int EV_START = 256;
  localparam int EV_STOP  = 512;

  logic       clk_25M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] address = 8'h00;
  logic       sda_in;
  logic       scl, sda_oe, data_valid, ready, no_ack;
  logic [7:0] data_out;
  logic       slave_low = 1'b0;
  logic       float_ack = 1'b0;

  // Open-drain bus with pull-up.
  assign sda_in = !(sda_oe || slave_low);

  sccb_reader #(
    .WR_ID         (8'h42),
    .RD_ID         (8'h43),
    .QUARTER_CYCLES(Q)
  ) dut (
    .clk_25M   (clk_25M),
    .rst_n     (rst_n),
    .start     (start),
    .address   (address),
    .sda_in    (sda_in),
    .scl       (scl),
    .sda_oe    (sda_oe),
    .data_out  (data_out),
    .data_valid(data_valid),
    .ready     (ready),
    .no_ack    (no_ack)
  );

  always #20 clk_25M = ~clk_25M;

  typedef struct {
    logic [7:0]  data;
    logic        noack;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          bus_q[$];
  int unsigned cyc  = 0;
  int          nvec = 0;
  int          nerr = 0;
  logic [7:0]  mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bus_event(input int ev);
    if (bus_q.size() == 0) check("unexpected_bus_event", ev, 32'hFFFF_FFFF);
    else check("bus_event", ev, bus_q.pop_front());
  endtask

  initial forever begin
    @(posedge clk_25M);
    cyc++;
  end

  // Output monitor: pops one expectation per data_valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_25M);
      if (rst_n && data_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_data_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("data_out", data_out, e.data);
          check("no_ack", no_ack, e.noack);
          check("valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // SCCB slave model and bus decoder.
  initial begin
    logic       prev_scl, prev_sda, s, rd_mode;
    logic [7:0] shreg, reg_ptr, rb;
    int         bitcnt, byte_idx;
    prev_scl = 1'b1; prev_sda = 1'b1; rd_mode = 1'b0;
    shreg = 8'h00; reg_ptr = 8'h00; rb = 8'h00;
    bitcnt = 0; byte_idx = 0;
    forever begin
      @(negedge clk_25M);
      s = sda_in;
      if (!rst_n) begin
        bitcnt = 0; byte_idx = 0; rd_mode = 1'b0; slave_low = 1'b0;
        prev_scl = 1'b1; prev_sda = 1'b1;
      end else begin
        if (scl && prev_scl && prev_sda && !s) begin
          bus_event(EV_START);
          bitcnt = 0; byte_idx = 0; rd_mode = 1'b0; slave_low = 1'b0;
        end else if (scl && prev_scl && !prev_sda && s) begin
          bus_event(EV_STOP);
          bitcnt = 0; byte_idx = 0; rd_mode = 1'b0; slave_low = 1'b0;
        end else if (scl && !prev_scl) begin
          if (bitcnt < 8) begin
            shreg = {shreg[6:0], s};
            bitcnt++;
            if (bitcnt == 8 && !(rd_mode && byte_idx == 1)) begin
              bus_event(int'(shreg));
              if (byte_idx == 0) rd_mode = shreg[0];
              else if (byte_idx == 1) reg_ptr = shreg;
            end
          end else begin
            bitcnt = 0;
            byte_idx++;
          end
        end else if (!scl && prev_scl) begin
          if (bitcnt == 8) begin
            slave_low = !(rd_mode && byte_idx == 1) && !float_ack;
          end else if (rd_mode && byte_idx == 1) begin
            rb = mem[reg_ptr];
            slave_low = !rb[7 - bitcnt];
          end else begin
            slave_low = 1'b0;
          end
        end
        prev_scl = scl;
        prev_sda = s;
      end
    end
  end

  task automatic tick();
    @(posedge clk_25M);
    #5;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_bus(input logic [7:0] a, input bit full);
    bus_q.push_back(EV_START); bus_q.push_back(8'h42); bus_q.push_back(int'(a));
    bus_q.push_back(EV_STOP);  bus_q.push_back(EV_START); bus_q.push_back(8'h43);
    if (full) bus_q.push_back(EV_STOP);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic na, input int unsigned c);
    exp_t e;
    e.data = d; e.noack = na; e.cyc = c;
    sb_q.push_back(e);
  endtask

  // One complete read issued while idle; returns at cycle 658 of it.
  task automatic do_read(input logic [7:0] a, input logic [7:0] d, input logic na);
    int unsigned c0;
    c0 = cyc;
    start = 1'b1; address = a;
    push_exp(d, na, c0 + DV_OFS);
    expect_bus(a, 1'b1);
    tick();
    start = 1'b0;
    check("accept_ready_low", ready, 0);
    check("accept_no_ack_clear", no_ack, 0);
    wait_cycles(RDY_OFS - 1);
    check("ready_after_read", ready, 1);
    check("data_hold", data_out, d);
  endtask

  initial begin
    int unsigned c0;
    int          hi;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'h10] = 8'h54; mem[8'h13] = 8'h8F; mem[8'h20] = 8'hC5;
    mem[8'h21] = 8'h2A; mem[8'h2A] = 8'hA5; mem[8'h0B] = 8'h7F;

    // T1 reset
    wait_cycles(3);
    check("rst_scl", scl, 1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_ready", ready, 1);
    check("rst_data_valid", data_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_no_ack", no_ack, 0);
    rst_n = 1'b1;
    wait_cycles(4);

    // T2 single read
    do_read(8'h10, 8'h54, 1'b0);
    wait_cycles(5);

    // T3 start pulses while busy are dropped
    c0 = cyc;
    start = 1'b1; address = 8'h10;
    push_exp(8'h54, 1'b0, c0 + DV_OFS);
    expect_bus(8'h10, 1'b1);
    tick();
    start = 1'b0;
    hi = ready ? 1 : 0;
    for (int i = 2; i < RDY_OFS; i++) begin
      tick();
      if (ready) hi++;
      start   = (i == 10 || i == 300);
      address = start ? 8'h13 : 8'h10;
    end
    check("busy_ready_high_cycles", hi, 0);
    tick();
    check("busy_ready_at_658", ready, 1);
    hi = 0;
    repeat (20) begin tick(); if (!ready) hi++; end
    check("busy_no_queued_txn", hi, 0);

    // T4 back-to-back with start held high
    c0 = cyc;
    start = 1'b1; address = 8'h20;
    push_exp(8'hC5, 1'b0, c0 + DV_OFS);
    push_exp(8'h2A, 1'b0, c0 + RDY_OFS + DV_OFS);
    expect_bus(8'h20, 1'b1);
    expect_bus(8'h21, 1'b1);
    tick();
    address = 8'h21;
    wait_cycles(RDY_OFS - 1);
    check("b2b_ready_at_658", ready, 1);
    tick();
    start = 1'b0;
    check("b2b_second_accepted", ready, 0);
    wait_cycles(RDY_OFS - 1);
    check("b2b_ready_end", ready, 1);
    wait_cycles(5);

    // T5 floating 9th bits, then a clean read clears no_ack
    float_ack = 1'b1;
    do_read(8'h13, 8'h8F, 1'b1);
    check("no_ack_holds", no_ack, 1);
    float_ack = 1'b0;
    wait_cycles(3);
    do_read(8'h10, 8'h54, 1'b0);
    wait_cycles(5);

    // T6 reset inside RX_DATA
    c0 = cyc;
    start = 1'b1; address = 8'h2A;
    expect_bus(8'h2A, 1'b0);
    tick();
    start = 1'b0;
    wait_cycles(499);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_scl", scl, 1);
    check("midrst_sda_oe", sda_oe, 0);
    check("midrst_ready", ready, 1);
    check("midrst_data_valid", data_valid, 0);
    check("midrst_data_out", data_out, 0);
    wait_cycles(200);
    do_read(8'h0B, 8'h7F, 1'b0);
    wait_cycles(10);

    check("scoreboard_drained", sb_q.size(), 0);
    check("bus_events_drained", bus_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation exceeded 20000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
